// File: rtl/traffic_pkg.sv
// Shared types and default timing for the intersection controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        MODE_EMG   = 2'd0,
        MODE_PED   = 2'd1,
        MODE_NIGHT = 2'd2,
        MODE_DAY   = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        PH_GREEN       = 3'd0,
        PH_YELLOW      = 3'd1,
        PH_ALL_RED     = 3'd2,
        PH_WALK        = 3'd3,
        PH_EMG         = 3'd4,
        PH_NIGHT_FLASH = 3'd5
    } phase_t;

    localparam int DEF_NUM_LANES   = 8;
    localparam int DEF_CNT_W       = 7;
    localparam int DEF_GREEN_MIN   = 5;
    localparam int DEF_YELLOW_T    = 3;
    localparam int DEF_ALLRED_T    = 2;
    localparam int DEF_WALK_T      = 15;
    localparam int DEF_NIGHT_START = 20;
    localparam int DEF_NIGHT_END   = 6;

endpackage

// File: rtl/phase_timer.sv
// Loadable tick-enabled down-counter; 'last' marks the final tick of a phase.
module phase_timer #(
    parameter int               CNT_W   = 7,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] r_count;

    // Load beats hold so a phase change always restarts the count; zero never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= RST_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && !hold && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign last  = (r_count == CNT_W'(1));

endmodule

// File: rtl/intersection_controller.sv
// Intersection sequencer: load-proportional round-robin greens with yellow/all-red
// clearance, latched pedestrian walk, emergency preemption and night flashing.
module intersection_controller
    import traffic_pkg::*;
#(
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GREEN_MIN   = DEF_GREEN_MIN,
    parameter int YELLOW_T    = DEF_YELLOW_T,
    parameter int ALLRED_T    = DEF_ALLRED_T,
    parameter int WALK_T      = DEF_WALK_T,
    parameter int NIGHT_START = DEF_NIGHT_START,
    parameter int NIGHT_END   = DEF_NIGHT_END
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tick,
    input  logic [4:0]                      hours_in,
    input  logic                            ped_req,
    input  logic                            emg_req,
    input  logic [NUM_LANES-1:0]            emg_lane,
    input  logic [NUM_LANES-1:0][CNT_W-1:0] lane_load,
    output logic [NUM_LANES-1:0]            green,
    output logic [NUM_LANES-1:0]            yellow,
    output logic                            walk,
    output logic [1:0]                      mode,
    output logic [CNT_W-1:0]                count
);

    localparam int               LANE_W        = $clog2(NUM_LANES);
    localparam logic [CNT_W-1:0] GREEN_MIN_C   = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] YELLOW_C      = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] ALLRED_C      = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] WALK_C        = CNT_W'(WALK_T);
    localparam logic [4:0]       NIGHT_START_H = 5'(NIGHT_START);
    localparam logic [4:0]       NIGHT_END_H   = 5'(NIGHT_END);
    localparam logic [4:0]       LAST_HOUR     = 5'd23;

    phase_t               r_state;
    logic [LANE_W-1:0]    r_cur;
    logic                 r_ped;
    logic [NUM_LANES-1:0] r_green;
    logic [NUM_LANES-1:0] r_yellow;
    logic                 r_walk;
    mode_t                r_mode;

    logic                 w_night;
    logic [LANE_W-1:0]    w_emg_sel;
    logic [LANE_W-1:0]    w_next_lane;
    logic [LANE_W-1:0]    w_idx;
    logic                 w_found;
    logic [CNT_W-1:0]     w_green_dur;
    logic                 w_go;
    phase_t               w_dest;
    mode_t                w_dest_mode;
    logic [CNT_W-1:0]     w_load_val;
    logic                 w_hold;
    logic                 w_last;
    logic [CNT_W-1:0]     w_count;

    function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_LANES) s = s - NUM_LANES;
        return LANE_W'(s);
    endfunction

    function automatic logic [NUM_LANES-1:0] lane_bit(input logic [LANE_W-1:0] idx);
        logic [NUM_LANES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // The night window wraps midnight; out-of-range hours count as day.
    assign w_night = (hours_in <= LAST_HOUR) &&
                     ((hours_in >= NIGHT_START_H) || (hours_in < NIGHT_END_H));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_emg_sel = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (emg_lane[i]) w_emg_sel = LANE_W'(i);
        end
    end

    // Round-robin from cur+1, skipping idle lanes; falls back to cur+1 when all are idle.
    always_comb begin
        w_next_lane = lane_add(r_cur, 1);
        w_idx       = '0;
        w_found     = 1'b0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            w_idx = lane_add(r_cur, k);
            if (!w_found && (lane_load[w_idx] != '0)) begin
                w_next_lane = w_idx;
                w_found     = 1'b1;
            end
        end
        w_green_dur = (lane_load[w_next_lane] > GREEN_MIN_C) ? lane_load[w_next_lane] : GREEN_MIN_C;
    end

    always_comb begin
        w_go   = 1'b0;
        w_dest = r_state;
        if (tick) begin
            unique case (r_state)
                PH_ALL_RED: begin
                    if (w_last) begin
                        w_go = 1'b1;
                        if (emg_req)      w_dest = PH_EMG;
                        else if (r_ped)   w_dest = PH_WALK;
                        else if (w_night) w_dest = PH_NIGHT_FLASH;
                        else              w_dest = PH_GREEN;
                    end
                end
                PH_GREEN: begin
                    if (emg_req) begin
                        w_go   = 1'b1;
                        w_dest = (w_emg_sel == r_cur) ? PH_EMG : PH_YELLOW;
                    end else if (w_last) begin
                        w_go   = 1'b1;
                        w_dest = PH_YELLOW;
                    end
                end
                PH_YELLOW: begin
                    if (w_last) begin
                        w_go   = 1'b1;
                        w_dest = PH_ALL_RED;
                    end
                end
                PH_WALK: begin
                    if (emg_req || w_last) begin
                        w_go   = 1'b1;
                        w_dest = PH_ALL_RED;
                    end
                end
                PH_EMG: begin
                    if (!emg_req) begin
                        w_go   = 1'b1;
                        w_dest = PH_YELLOW;
                    end
                end
                PH_NIGHT_FLASH: begin
                    if (emg_req || r_ped || !w_night) begin
                        w_go   = 1'b1;
                        w_dest = PH_ALL_RED;
                    end
                end
                default: begin
                    w_go   = 1'b1;
                    w_dest = PH_ALL_RED;
                end
            endcase
        end
    end

    // Clearance started by preemption shows EMG; the all-red after a yellow inherits its mode.
    always_comb begin
        w_dest_mode = MODE_DAY;
        w_load_val  = '0;
        unique case (w_dest)
            PH_GREEN: w_load_val = w_green_dur;
            PH_YELLOW: begin
                w_load_val = YELLOW_C;
                if ((r_state == PH_GREEN) && emg_req) w_dest_mode = MODE_EMG;
            end
            PH_ALL_RED: begin
                w_load_val = ALLRED_C;
                if (r_state == PH_YELLOW) w_dest_mode = r_mode;
                else if (emg_req)         w_dest_mode = MODE_EMG;
            end
            PH_WALK: begin
                w_load_val  = WALK_C;
                w_dest_mode = MODE_PED;
            end
            PH_EMG:         w_dest_mode = MODE_EMG;
            PH_NIGHT_FLASH: w_dest_mode = MODE_NIGHT;
            default: ;
        endcase
    end

    assign w_hold = (r_state == PH_EMG) || (r_state == PH_NIGHT_FLASH);

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_C)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (w_go),
        .load_val (w_load_val),
        .hold     (w_hold),
        .count    (w_count),
        .last     (w_last)
    );

    // NOTE: sequential state uses non-blocking assignments; the later WALK-entry clear
    // of r_ped deliberately overrides the earlier set within the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= PH_ALL_RED;
            r_cur    <= LANE_W'(NUM_LANES - 1);
            r_ped    <= 1'b0;
            r_green  <= '0;
            r_yellow <= '0;
            r_walk   <= 1'b0;
            r_mode   <= MODE_DAY;
        end else begin
            if (ped_req) r_ped <= 1'b1;
            if (w_go) begin
                r_state  <= w_dest;
                r_mode   <= w_dest_mode;
                r_green  <= '0;
                r_yellow <= '0;
                r_walk   <= 1'b0;
                unique case (w_dest)
                    PH_GREEN: begin
                        r_cur   <= w_next_lane;
                        r_green <= lane_bit(w_next_lane);
                    end
                    PH_YELLOW:      r_yellow <= lane_bit(r_cur);
                    PH_WALK: begin
                        r_ped  <= 1'b0;
                        r_walk <= 1'b1;
                    end
                    PH_EMG: begin
                        r_cur   <= w_emg_sel;
                        r_green <= lane_bit(w_emg_sel);
                    end
                    PH_NIGHT_FLASH: r_yellow <= '1;
                    default: ;
                endcase
            end else if (tick && (r_state == PH_NIGHT_FLASH)) begin
                r_yellow <= ~r_yellow;
            end
        end
    end

    assign green  = r_green;
    assign yellow = r_yellow;
    assign walk   = r_walk;
    assign mode   = r_mode;
    assign count  = w_count;

endmodule

// File: tb/tb_intersection_controller.sv
// Scoreboard bench for intersection_controller with a tick-level phase/timer model.
module tb_intersection_controller;

    localparam int NL   = 4;
    localparam int LW   = 2;
    localparam int CW   = 7;
    localparam int G_MIN = 5;
    localparam int Y_T  = 3;
    localparam int AR_T = 2;
    localparam int W_T  = 15;

    logic                  clk      = 1'b0;
    logic                  rst      = 1'b0;
    logic                  tick     = 1'b0;
    logic [4:0]            hours_in = 5'd12;
    logic                  ped_req  = 1'b0;
    logic                  emg_req  = 1'b0;
    logic [NL-1:0]         emg_lane = 4'b0001;
    logic [NL-1:0][CW-1:0] lane_load;
    logic [NL-1:0]         green;
    logic [NL-1:0]         yellow;
    logic                  walk;
    logic [1:0]            mode;
    logic [CW-1:0]         count;

    intersection_controller #(
        .NUM_LANES(NL), .CNT_W(CW), .GREEN_MIN(G_MIN), .YELLOW_T(Y_T),
        .ALLRED_T(AR_T), .WALK_T(W_T), .NIGHT_START(20), .NIGHT_END(6)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .hours_in(hours_in), .ped_req(ped_req),
        .emg_req(emg_req), .emg_lane(emg_lane), .lane_load(lane_load),
        .green(green), .yellow(yellow), .walk(walk), .mode(mode), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0] g;
        logic [NL-1:0] y;
        logic          w;
        logic [1:0]    m;
        logic [CW-1:0] c;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_exp;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase name, ticks remaining, served lane, latched ped, flash phase.
    typedef enum int {M_GREEN, M_YELLOW, M_AR, M_WALK, M_EMG, M_NIGHT} mph_t;
    mph_t m_ph;
    int   m_rem, m_cur, m_mode;
    bit   m_ped, m_flash;

    function automatic bit is_night(input int h);
        return (h <= 23) && ((h >= 20) || (h < 6));
    endfunction

    function automatic int low_bit(input logic [NL-1:0] v);
        for (int i = 0; i < NL; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int pick_lane(input int from);
        for (int k = 1; k <= NL; k++)
            if (lane_load[LW'((from + k) % NL)] != 0) return (from + k) % NL;
        return (from + 1) % NL;
    endfunction

    task automatic model_reset();
        m_ph = M_AR; m_rem = AR_T; m_cur = NL - 1; m_ped = 0; m_flash = 0; m_mode = 3;
    endtask

    task automatic model_step();
        bit emg;
        int sel, ld;
        emg = emg_req;
        sel = low_bit(emg_lane);
        case (m_ph)
            M_AR: begin
                m_rem--;
                if (m_rem == 0) begin
                    if (emg) begin
                        m_ph = M_EMG; m_cur = sel; m_rem = 0; m_mode = 0;
                    end else if (m_ped) begin
                        m_ph = M_WALK; m_ped = 0; m_rem = W_T; m_mode = 1;
                    end else if (is_night(hours_in)) begin
                        m_ph = M_NIGHT; m_flash = 1; m_rem = 0; m_mode = 2;
                    end else begin
                        m_cur = pick_lane(m_cur);
                        ld = int'(lane_load[LW'(m_cur)]);
                        m_ph = M_GREEN; m_rem = (ld > G_MIN) ? ld : G_MIN; m_mode = 3;
                    end
                end
            end
            M_GREEN: begin
                if (emg && sel == m_cur) begin
                    m_ph = M_EMG; m_rem = 0; m_mode = 0;
                end else if (emg) begin
                    m_ph = M_YELLOW; m_rem = Y_T; m_mode = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin m_ph = M_YELLOW; m_rem = Y_T; m_mode = 3; end
                end
            end
            M_YELLOW: begin
                m_rem--;
                if (m_rem == 0) begin m_ph = M_AR; m_rem = AR_T; end
            end
            M_WALK: begin
                if (emg) begin
                    m_ph = M_AR; m_rem = AR_T; m_mode = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin m_ph = M_AR; m_rem = AR_T; m_mode = 3; end
                end
            end
            M_EMG: begin
                if (!emg) begin m_ph = M_YELLOW; m_rem = Y_T; m_mode = 3; end
            end
            default: begin
                if (emg || m_ped || !is_night(hours_in)) begin
                    m_ph = M_AR; m_rem = AR_T; m_mode = emg ? 0 : 3;
                end else begin
                    m_flash = !m_flash;
                end
            end
        endcase
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.g = (m_ph == M_GREEN || m_ph == M_EMG) ? (NL'(1) << m_cur) : '0;
        o.y = (m_ph == M_YELLOW) ? (NL'(1) << m_cur) : ((m_ph == M_NIGHT && m_flash) ? '1 : '0);
        o.w = (m_ph == M_WALK);
        o.m = 2'(m_mode);
        o.c = CW'(m_rem);
        return o;
    endfunction

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        model_step();
        exp_q.push_back(model_obs());
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic pulse_ped();
        @(negedge clk);
        ped_req = 1'b1;
        m_ped   = 1;
        @(negedge clk);
        ped_req = 1'b0;
    endtask

    task automatic wait_green(input int lane, input int rem);
        int n;
        n = 0;
        while (!(m_ph == M_GREEN && m_cur == lane && (rem < 0 || m_rem == rem)) && n < 100) begin
            do_tick();
            n++;
        end
        @(negedge clk);
        check("reach_green_lane", green, NL'(1) << lane);
    endtask

    // Monitor: the DUT presents a new result one clock after every tick pulse.
    logic          tick_seen = 1'b0;
    logic [NL-1:0] acc_green = '0;
    always @(posedge clk) tick_seen <= tick;

    always @(negedge clk) begin
        if (tick_seen) begin
            if (exp_q.size() == 0) begin
                check("queue_underflow", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("lamps_walk_mode_count", {green, yellow, walk, mode, count}, mon_exp);
                acc_green = acc_green | green;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lane_load    = '0;
        lane_load[1] = CW'(8);
        lane_load[2] = CW'(2);
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_green", green, 0);
        check("reset_yellow", yellow, 0);
        check("reset_walk", walk, 0);
        check("reset_mode", mode, 3);
        check("reset_count", count, AR_T);
        rst = 1'b1;

        // Loads {0,8,2,0}: AR 2, lane1 8, yellow 3, AR 2, lane2 5 (minimum green).
        repeat (22) do_tick();
        @(negedge clk);
        check("lanes0_3_never_green", acc_green & 4'b1001, 0);

        // Pedestrian pulse during lane1 green is served after its clearance.
        wait_green(1, -1);
        pulse_ped();
        repeat (40) do_tick();

        // Emergency to lane3 while lane1 green at count 6.
        wait_green(1, 6);
        emg_lane = 4'b1000;
        emg_req  = 1'b1;
        repeat (10) do_tick();
        emg_req = 1'b0;
        repeat (12) do_tick();

        // Emergency for the lane already green: no clearance, no gap.
        wait_green(2, -1);
        emg_lane = 4'b0100;
        emg_req  = 1'b1;
        repeat (4) do_tick();
        emg_req = 1'b0;
        repeat (10) do_tick();

        // Night window entry and exit at its boundaries.
        wait_green(1, -1);
        hours_in = 5'd19;
        do_tick();
        hours_in = 5'd20;
        repeat (20) do_tick();
        hours_in = 5'd5;
        repeat (3) do_tick();
        hours_in = 5'd6;
        repeat (12) do_tick();

        // Asynchronous reset in the middle of a yellow.
        begin
            int n;
            n = 0;
            while (!(m_ph == M_YELLOW && m_rem == 2) && n < 100) begin
                do_tick();
                n++;
            end
        end
        @(negedge clk);
        check("reach_yellow", (yellow != 0), 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_green", green, 0);
        check("midrst_yellow", yellow, 0);
        check("midrst_walk", walk, 0);
        check("midrst_mode", mode, 3);
        check("midrst_count", count, AR_T);
        check("midrst_queue_drained", exp_q.size(), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (12) do_tick();

        // Randomised traffic, hours (including >23), emergencies and pedestrian pulses.
        repeat (400) begin
            if ($urandom_range(0, 19) == 0)
                for (int i = 0; i < NL; i++)
                    lane_load[i] = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom_range(1, 20));
            if ($urandom_range(0, 29) == 0) hours_in = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 24) == 0) begin
                emg_req = ~emg_req;
                if (emg_req) emg_lane = NL'($urandom_range(1, 15));
            end
            if ($urandom_range(0, 29) == 0) pulse_ped();
            do_tick();
        end
        emg_req = 1'b0;

        repeat (2) @(negedge clk);
        check("queue_empty_at_end", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/intersection_controller.md
# intersection_controller

Parametrised intersection controller for NUM_LANES signal heads, generalising the fixed 8-lane board top. It merges mode selection and light sequencing into one sequencer with load-proportional green times, mandatory yellow/all-red clearance, latched pedestrian service, emergency preemption and a night flashing mode. It sits directly under the board top level and drives the lamp outputs.

## Interface
- NUM_LANES, 8, number of approach lanes (2..16)
- CNT_W, 7, phase timer width; max duration 2^CNT_W-1 ticks
- GREEN_MIN, 5, minimum green ticks
- YELLOW_T, 3, yellow ticks
- ALLRED_T, 2, all-red clearance ticks
- WALK_T, 15, walk ticks
- NIGHT_START, 20 / NIGHT_END, 6, night window hours (inclusive start, exclusive end)

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- tick  in  1  1 Hz enable, single-cycle pulse; all timing counts ticks
- hours_in  in  5  hour of day 0..23; values above 23 treated as day
- ped_req  in  1  pedestrian button, level or pulse
- emg_req  in  1  emergency request, level
- emg_lane  in  NUM_LANES  one-hot lane to preempt to; lowest set bit wins if not one-hot
- lane_load  in  NUM_LANES x CNT_W  per-lane queue estimate
- green  out  NUM_LANES  green lamps, at most one bit set
- yellow  out  NUM_LANES  yellow lamps
- walk  out  1  pedestrian walk lamp
- mode  out  2  0 EMG, 1 PED, 2 NIGHT, 3 DAY
- count  out  CNT_W  remaining ticks in current phase

## Operation
- States: GREEN, YELLOW, ALL_RED, WALK, EMG, NIGHT_FLASH. Lane pointer cur selects the lane for GREEN/YELLOW.
- Night = hours_in >= NIGHT_START or hours_in < NIGHT_END (wrap across midnight).
- Reset: state ALL_RED, count=ALLRED_T, cur=NUM_LANES-1, ped latch 0, flash 0, green=0, yellow=0, walk=0, mode=DAY.
- ped_req sets ped latch on any cycle. The latch is cleared on WALK entry.
- Priority on leaving ALL_RED: emg_req -> EMG; ped latch -> WALK; night -> NIGHT_FLASH; else -> GREEN on next lane.
- Next lane: round-robin from cur+1 (wrap), skipping lanes with lane_load==0. If all loads are zero, take cur+1.
- GREEN duration = max(GREEN_MIN, lane_load[lane]); CNT_W-bit, no overflow by construction.
- GREEN -> YELLOW (YELLOW_T) -> ALL_RED (ALLRED_T).
- Preemption: emg_req in GREEN on a lane other than the emergency lane forces YELLOW on the next tick. If the emergency lane is already green, go to EMG immediately with no clearance. In WALK, go to ALL_RED on the next tick.
- EMG: green on emg_lane, count held at 0. When emg_req drops, go to YELLOW on that lane, then normal flow with cur=emg_lane.
- NIGHT_FLASH: green=0, yellow toggles all-ones/all-zeros each tick, count=0. Leave to ALL_RED on the first tick where not night, or on emg_req/ped latch.
- WALK: walk=1, all green=0, WALK_T ticks, then ALL_RED.
- mode reflects the served state. EMG=0; WALK=1; NIGHT_FLASH=2; GREEN/YELLOW/ALL_RED=3, except clearance phases entered by preemption show 0.

## Timing
- Outputs are registered and update the cycle after the causing tick or input edge.
- On phase entry count=D. It decrements on each tick. The phase exits on the tick where count==1, so a phase lasts exactly D ticks. D is always >=1 for timed phases.
- Async reset mid-phase forces reset values immediately. The first lamp change after deassertion is the ALLRED_T tick.
- emg_req is sampled every clk. Preemption acts on the next tick; it is never delayed by the remaining green time.
- Simultaneous emg_req and ped latch: EMG first; the ped latch is retained.

## Structure
- Package traffic_pkg: mode_t (EMG/PED/NIGHT/DAY encoding above), phase_t state enum, default timing constants.
- Sub-module phase_timer: CNT_W loadable down-counter with tick enable, load and hold inputs, and a last flag (count==1). It succeeds the saturation timer.
- Round-robin lane select and the night decode are local combinational logic.

## Test plan
- NUM_LANES=4, loads {0,8,2,0}, day: after reset, ALL_RED 2 ticks, lane1 green 8 ticks, yellow 3, ALL_RED 2, then lane2 green 5 ticks (GREEN_MIN). Lanes 0 and 3 are never green.
- Pulse ped_req during lane1 green: lane1 finishes, yellow, ALL_RED, then WALK 15 ticks with walk=1 and mode=1, then ALL_RED, then lane2.
- emg_req with emg_lane=lane3 during lane1 green at count=6: yellow on the next tick, ALL_RED 2, then green[3] held while emg_req is high. On release: yellow lane3, then continue.
- emg_req for the lane currently green: EMG on the next tick, with no yellow and no gap in green.
- hours_in 19->20 during GREEN: phase completes, then NIGHT_FLASH with yellow toggling each tick and mode=2. hours_in=6 returns to ALL_RED then GREEN. hours_in=5 stays in night.
- Assert rst low mid-YELLOW: all lamps 0, count=2 immediately, sequence restarts from ALL_RED.
